token_table_loader: RTL and testbench
=====================================

// Module: token_table_loader
// PURPOSE
//  Boot/reload sequencer for the instruction decompressor. After reset it walks a token image
//  in instruction memory (header word + N token words), writes each token into the decompressor
//  token table over its write port, then hands the imem read port to the decompressor fetch path.
//  Holds the CPU stalled while loading. Sits between the decompressor and imem in the top level.
// PARAMETERS
//  WIDTH       32          data/address width
//  PCADD       32'b100     byte increment between consecutive words
//  ENCODE_LEN  4           token index width; table depth = 2**ENCODE_LEN (16)
//  TOKEN_BASE  32'h100     byte address of header word
//  HDR_MAGIC   16'hC0DE    required value of header[31:16]
// PORTS
//  clk            in   1             clock
//  reset          in   1             async, active-high
//  reload_req     in   1             request to re-run the load sequence
//  fetch_addr     in   WIDTH         decompressor fetch address (PCcompress)
//  fetch_rdata    out  WIDTH         word returned to decompressor (NextInstr)
//  imem_addr      out  WIDTH         imem read address
//  imem_rdata     in   WIDTH         imem read data, combinational from imem_addr
//  tt_we          out  1             token table write enable (wme)
//  tt_waddr       out  ENCODE_LEN    token table write index
//  tt_wdata       out  WIDTH         token table write data (WriteData)
//  cpu_stall      out  1             1 = CPU must hold PC
//  load_err       out  1             bad header; sticky until reload_req or reset
//  tokens_loaded  out  ENCODE_LEN+1  count of tokens written by last completed load
// BEHAVIOUR
//  - One clock (clk); reset async active-high. In reset: state=S_HDR, idx=0, count=0, load_err=0,
//    tokens_loaded=0, tt_we=0, cpu_stall=1.
//  - States: S_HDR, S_LOAD, S_RUN, S_ERR. Outputs decode combinationally from state/idx.
//  - S_HDR: imem_addr=TOKEN_BASE. count=imem_rdata[ENCODE_LEN:0] (upper bits of [15:0] must be 0).
//    magic mismatch, or count > 2**ENCODE_LEN, or nonzero [15:ENCODE_LEN+1] -> S_ERR (load_err=1).
//    count==0 -> S_RUN, tokens_loaded=0. Else latch count, idx=0 -> S_LOAD.
//  - S_LOAD: imem_addr=TOKEN_BASE+PCADD*(idx+1) (WIDTH-bit, wraps mod 2**WIDTH);
//    tt_we=1, tt_waddr=idx[ENCODE_LEN-1:0], tt_wdata=imem_rdata. idx++ each cycle;
//    on idx==count-1 -> S_RUN, tokens_loaded=count. One token per cycle, no bubbles.
//  - S_RUN: imem_addr=fetch_addr, fetch_rdata=imem_rdata, cpu_stall=0, tt_we=0.
//    reload_req=1 -> S_HDR next edge (cpu_stall=1 from that cycle).
//  - S_ERR: cpu_stall=1, load_err=1, imem_addr=TOKEN_BASE; reload_req -> S_HDR, clear load_err.
//  - Outside S_RUN: fetch_rdata=0; imem_addr never driven from fetch_addr.
//  - reload_req ignored in S_HDR/S_LOAD (no restart, no queueing).
//  - Latency: N-token image: reset release edge -> S_HDR 1 cycle, N S_LOAD cycles, cpu_stall
//    falls at start of cycle N+1.
//  - Reset mid-load: immediate return to reset values; table not cleared (partial contents
//    overwritten by next load). tokens_loaded updates only on completed load.
// STRUCTURE
//  - Package decomp_pkg: state enum ld_state_t, HDR_MAGIC, header field positions/widths.
//  - Sub-module imem_port_mux: 2:1 address steer (loader/fetch) + fetch_rdata gating by state.
//  - FSM, idx/count registers and tokens_loaded in this module.
// TESTING
//  1. Header 32'hC0DE_0003 @0x100, tokens 0xA1,0xB2,0xC3 @0x104..0x10C -> tt_we cycles 1-3
//     addrs 0,1,2 data A1,B2,C3; cpu_stall=0 cycle 4; tokens_loaded=3.
//  2. Header 32'hC0DE_0000 -> no tt_we; cpu_stall=0 cycle 1; tokens_loaded=0.
//  3. Header 32'hBEEF_0002 -> load_err=1, cpu_stall stays 1, no tt_we; fix memory, pulse
//     reload_req -> full 2-token load, load_err=0.
//  4. Header 32'hC0DE_0011 (17) -> load_err=1; 32'hC0DE_0010 (16) -> 16 writes, addrs 0..15.
//  5. In S_RUN, fetch_addr=0x40 -> imem_addr=0x40, fetch_rdata=mem[0x40]; reload_req ->
//     next cycle cpu_stall=1, imem_addr=0x100, fetch_rdata=0; reload_req during S_LOAD ignored.
//  6. Assert reset during token idx 2 of 5 -> reset values asynchronously; release -> restart
//     at header, 5 writes from idx 0, tokens_loaded=5 only at completion.

Source files
------------

// File: rtl/decomp_pkg.sv
// Shared types and header layout for the decompressor token-table loader.
package decomp_pkg;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } ld_state_t;

  localparam logic [15:0] HDR_MAGIC = 16'hC0DE;

  // Header word: [31:16] magic, [15:0] token count field.
  localparam int unsigned HDR_MAGIC_LSB = 16;
  localparam int unsigned HDR_MAGIC_W   = 16;
  localparam int unsigned HDR_CNT_LSB   = 0;
  localparam int unsigned HDR_CNT_W     = 16;

endpackage

// File: rtl/token_table_loader_imem_port_mux.sv
// Steers the imem read port between the loader and the decompressor fetch path.
module imem_port_mux
  import decomp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  ld_state_t        state,
  input  logic [WIDTH-1:0] loader_addr,
  input  logic [WIDTH-1:0] fetch_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] fetch_rdata
);

  logic run;

  assign run         = (state == S_RUN);
  assign imem_addr   = run ? fetch_addr : loader_addr;
  assign fetch_rdata = run ? imem_rdata : '0;

endmodule

// File: rtl/token_table_loader.sv
// Boot/reload sequencer: copies the token image from imem into the decompressor
// token table, stalling the CPU until the table is ready.
module token_table_loader
  import decomp_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] PCADD      = WIDTH'(4),
  parameter int unsigned      ENCODE_LEN = 4,
  parameter logic [WIDTH-1:0] TOKEN_BASE = WIDTH'(32'h100),
  parameter logic [15:0]      HDR_MAGIC  = decomp_pkg::HDR_MAGIC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload_req,
  input  logic [WIDTH-1:0]      fetch_addr,
  output logic [WIDTH-1:0]      fetch_rdata,
  output logic [WIDTH-1:0]      imem_addr,
  input  logic [WIDTH-1:0]      imem_rdata,
  output logic                  tt_we,
  output logic [ENCODE_LEN-1:0] tt_waddr,
  output logic [WIDTH-1:0]      tt_wdata,
  output logic                  cpu_stall,
  output logic                  load_err,
  output logic [ENCODE_LEN:0]   tokens_loaded
);

  localparam int unsigned DEPTH = 1 << ENCODE_LEN;

  ld_state_t             state;
  logic [ENCODE_LEN:0]   idx;
  logic [ENCODE_LEN:0]   count;

  logic [HDR_MAGIC_W-1:0] hdr_magic;
  logic [HDR_CNT_W-1:0]   hdr_cnt_field;
  logic [ENCODE_LEN:0]    hdr_count;
  logic                   hdr_upper_nz;
  logic                   hdr_bad;

  logic [WIDTH-1:0] idx_next_w;
  logic [WIDTH-1:0] load_addr;
  logic [WIDTH-1:0] loader_addr;

  assign hdr_magic     = imem_rdata[HDR_MAGIC_LSB +: HDR_MAGIC_W];
  assign hdr_cnt_field = imem_rdata[HDR_CNT_LSB +: HDR_CNT_W];
  assign hdr_count     = hdr_cnt_field[ENCODE_LEN:0];
  assign hdr_upper_nz  = |(hdr_cnt_field >> (ENCODE_LEN + 1));
  assign hdr_bad       = (hdr_magic != HDR_MAGIC) || hdr_upper_nz
                       || (hdr_count > DEPTH[ENCODE_LEN:0]);

  // Token k lives one word past the header, so the fetch address leads idx by one.
  assign idx_next_w  = WIDTH'(idx) + WIDTH'(1);
  assign load_addr   = TOKEN_BASE + PCADD * idx_next_w;
  assign loader_addr = (state == S_LOAD) ? load_addr : TOKEN_BASE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_HDR;
      idx           <= '0;
      count         <= '0;
      tokens_loaded <= '0;
    end else begin
      case (state)
        S_HDR: begin
          if (hdr_bad) begin
            state <= S_ERR;
          end else if (hdr_count == '0) begin
            state         <= S_RUN;
            tokens_loaded <= '0;
          end else begin
            count <= hdr_count;
            idx   <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          idx <= idx + 1'b1;
          if (idx == count - 1'b1) begin
            state         <= S_RUN;
            tokens_loaded <= count;
          end
        end
        S_RUN: begin
          if (reload_req) state <= S_HDR;
        end
        S_ERR: begin
          if (reload_req) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

  assign tt_we     = (state == S_LOAD);
  assign tt_waddr  = idx[ENCODE_LEN-1:0];
  assign tt_wdata  = tt_we ? imem_rdata : '0;
  assign cpu_stall = (state != S_RUN);
  assign load_err  = (state == S_ERR);

  imem_port_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .state      (state),
    .loader_addr(loader_addr),
    .fetch_addr (fetch_addr),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .fetch_rdata(fetch_rdata)
  );

endmodule

// File: tb/tb_token_table_loader.sv
// Directed bench for token_table_loader against a behavioural imem array.
module tb_token_table_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reload_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic [31:0] fetch_rdata;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        tt_we;
  logic [3:0]  tt_waddr;
  logic [31:0] tt_wdata;
  logic        cpu_stall;
  logic        load_err;
  logic [4:0]  tokens_loaded;

  logic [31:0] mem [0:255];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];

  token_table_loader #(
    .WIDTH(32), .PCADD(32'd4), .ENCODE_LEN(4), .TOKEN_BASE(32'h100), .HDR_MAGIC(16'hC0DE)
  ) dut (
    .clk(clk), .reset(reset), .reload_req(reload_req),
    .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .tt_we(tt_we), .tt_waddr(tt_waddr), .tt_wdata(tt_wdata),
    .cpu_stall(cpu_stall), .load_err(load_err), .tokens_loaded(tokens_loaded)
  );

  // Header at word 0x40 (byte 0x100), token i at word 0x41+i with data base+i.
  task automatic write_image(input logic [31:0] hdr, input int unsigned n, input logic [31:0] base);
    mem[8'h40] = hdr;
    for (int unsigned i = 0; i < n; i++) mem[8'h41 + i] = base + i;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic pulse_reload();
    reload_req = 1'b1;
    @(negedge clk);
    reload_req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    write_image(32'hC0DE_0003, 0, 32'h0);
    reset = 1'b1;
    #1;
    vectors++;
    if ({cpu_stall, tt_we, load_err, tokens_loaded} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want %b", {cpu_stall, tt_we, load_err, tokens_loaded}, 8'b1000_0000);
    end
    vectors++;
    if ({imem_addr, fetch_rdata} !== {32'h100, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_addr: got %h/%h want 00000100/00000000", imem_addr, fetch_rdata);
    end
  endtask

  task automatic test_load3();
    logic [31:0] exp_d [3];
    exp_d = '{32'hA1, 32'hB2, 32'hC3};
    write_image(32'hC0DE_0003, 0, 32'h0);
    mem[8'h41] = 32'hA1; mem[8'h42] = 32'hB2; mem[8'h43] = 32'hC3;
    @(negedge clk);
    pulse_reset();
    vectors++;
    if ({cpu_stall, tt_we, imem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL load3_c0: got stall=%b we=%b addr=%h want 1 0 00000100", cpu_stall, tt_we, imem_addr);
    end
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({tt_we, tt_waddr, tt_wdata, cpu_stall, tokens_loaded} !== {1'b1, 4'(k - 1), exp_d[k-1], 1'b1, 5'd0}) begin
        miscompares++;
        $display("FAIL load3_wr%0d: got we=%b a=%0d d=%h st=%b tl=%0d want 1 %0d %h 1 0",
                 k, tt_we, tt_waddr, tt_wdata, cpu_stall, tokens_loaded, k - 1, exp_d[k-1]);
      end
      vectors++;
      if (imem_addr !== 32'h100 + 4 * k) begin
        miscompares++;
        $display("FAIL load3_addr%0d: got %h want %h", k, imem_addr, 32'h100 + 4 * k);
      end
    end
    @(negedge clk);
    vectors++;
    if ({cpu_stall, tt_we, tokens_loaded} !== {1'b0, 1'b0, 5'd3}) begin
      miscompares++;
      $display("FAIL load3_done: got st=%b we=%b tl=%0d want 0 0 3", cpu_stall, tt_we, tokens_loaded);
    end
  endtask

  task automatic test_empty();
    write_image(32'hC0DE_0000, 0, 32'h0);
    pulse_reset();
    vectors++;
    if ({cpu_stall, tt_we} !== 2'b10) begin
      miscompares++;
      $display("FAIL empty_c0: got st=%b we=%b want 1 0", cpu_stall, tt_we);
    end
    @(negedge clk);
    vectors++;
    if ({cpu_stall, tt_we, load_err, tokens_loaded} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL empty_c1: got st=%b we=%b err=%b tl=%0d want 0 0 0 0", cpu_stall, tt_we, load_err, tokens_loaded);
    end
  endtask

  task automatic test_bad_magic();
    write_image(32'hBEEF_0002, 2, 32'h7700_0000);
    pulse_reset();
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({load_err, cpu_stall, tt_we, imem_addr} !== {1'b1, 1'b1, 1'b0, 32'h100}) begin
        miscompares++;
        $display("FAIL badmagic_c%0d: got err=%b st=%b we=%b addr=%h want 1 1 0 00000100",
                 k, load_err, cpu_stall, tt_we, imem_addr);
      end
    end
    write_image(32'hC0DE_0002, 2, 32'h7700_0000);
    pulse_reload();
    vectors++;
    if ({load_err, cpu_stall, tt_we} !== 3'b010) begin
      miscompares++;
      $display("FAIL badmagic_reload: got err=%b st=%b we=%b want 0 1 0", load_err, cpu_stall, tt_we);
    end
    for (int unsigned k = 1; k <= 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({tt_we, tt_waddr, tt_wdata} !== {1'b1, 4'(k - 1), 32'h7700_0000 + k - 1}) begin
        miscompares++;
        $display("FAIL badmagic_wr%0d: got we=%b a=%0d d=%h want 1 %0d %h",
                 k, tt_we, tt_waddr, tt_wdata, k - 1, 32'h7700_0000 + k - 1);
      end
    end
    @(negedge clk);
    vectors++;
    if ({cpu_stall, load_err, tokens_loaded} !== {1'b0, 1'b0, 5'd2}) begin
      miscompares++;
      $display("FAIL badmagic_done: got st=%b err=%b tl=%0d want 0 0 2", cpu_stall, load_err, tokens_loaded);
    end
  endtask

  task automatic test_count_limits();
    write_image(32'hC0DE_0011, 0, 32'h0);
    pulse_reset();
    @(negedge clk);
    vectors++;
    if ({load_err, cpu_stall, tt_we} !== 3'b110) begin
      miscompares++;
      $display("FAIL count17: got err=%b st=%b we=%b want 1 1 0", load_err, cpu_stall, tt_we);
    end
    // Count field bits above ENCODE_LEN must be zero even when the low bits are legal.
    write_image(32'hC0DE_0020, 0, 32'h0);
    pulse_reload();
    @(negedge clk);
    vectors++;
    if ({load_err, tt_we} !== 2'b10) begin
      miscompares++;
      $display("FAIL count_upper: got err=%b we=%b want 1 0", load_err, tt_we);
    end
    write_image(32'hC0DE_0010, 16, 32'h3300_0000);
    pulse_reload();
    for (int unsigned k = 1; k <= 16; k++) begin
      @(negedge clk);
      vectors++;
      if ({tt_we, tt_waddr, tt_wdata, imem_addr} !== {1'b1, 4'(k - 1), 32'h3300_0000 + k - 1, 32'h100 + 4 * k}) begin
        miscompares++;
        $display("FAIL count16_wr%0d: got we=%b a=%0d d=%h addr=%h want 1 %0d %h %h",
                 k, tt_we, tt_waddr, tt_wdata, imem_addr, k - 1, 32'h3300_0000 + k - 1, 32'h100 + 4 * k);
      end
    end
    @(negedge clk);
    vectors++;
    if ({cpu_stall, load_err, tokens_loaded} !== {1'b0, 1'b0, 5'd16}) begin
      miscompares++;
      $display("FAIL count16_done: got st=%b err=%b tl=%0d want 0 0 16", cpu_stall, load_err, tokens_loaded);
    end
  endtask

  task automatic test_fetch_and_reload();
    mem[8'h10] = 32'hDEAD_BEEF;
    fetch_addr = 32'h40;
    #1;
    vectors++;
    if ({imem_addr, fetch_rdata} !== {32'h40, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL fetch_run: got addr=%h data=%h want 00000040 deadbeef", imem_addr, fetch_rdata);
    end
    write_image(32'hC0DE_0003, 3, 32'h9900_0000);
    pulse_reload();
    vectors++;
    if ({cpu_stall, imem_addr, fetch_rdata} !== {1'b1, 32'h100, 32'h0}) begin
      miscompares++;
      $display("FAIL fetch_reload: got st=%b addr=%h data=%h want 1 00000100 00000000", cpu_stall, imem_addr, fetch_rdata);
    end
    @(negedge clk);
    vectors++;
    if ({tt_we, tt_waddr, fetch_rdata} !== {1'b1, 4'd0, 32'h0}) begin
      miscompares++;
      $display("FAIL fetch_ld0: got we=%b a=%0d data=%h want 1 0 00000000", tt_we, tt_waddr, fetch_rdata);
    end
    reload_req = 1'b1;
    @(negedge clk);
    reload_req = 1'b0;
    #1;
    vectors++;
    if ({tt_we, tt_waddr, tt_wdata} !== {1'b1, 4'd1, 32'h9900_0001}) begin
      miscompares++;
      $display("FAIL reload_in_load: got we=%b a=%0d d=%h want 1 1 99000001", tt_we, tt_waddr, tt_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({cpu_stall, tokens_loaded, imem_addr} !== {1'b0, 5'd3, 32'h40}) begin
      miscompares++;
      $display("FAIL reload_done: got st=%b tl=%0d addr=%h want 0 3 00000040", cpu_stall, tokens_loaded, imem_addr);
    end
    fetch_addr = '0;
  endtask

  task automatic test_reset_midload();
    write_image(32'hC0DE_0005, 5, 32'h1200_0000);
    pulse_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({tt_we, tt_waddr} !== {1'b1, 4'd2}) begin
      miscompares++;
      $display("FAIL midload_pre: got we=%b a=%0d want 1 2", tt_we, tt_waddr);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({cpu_stall, tt_we, load_err, tokens_loaded, imem_addr} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'h100}) begin
      miscompares++;
      $display("FAIL midload_async: got st=%b we=%b err=%b tl=%0d addr=%h want 1 0 0 0 00000100",
               cpu_stall, tt_we, load_err, tokens_loaded, imem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int unsigned k = 1; k <= 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({tt_we, tt_waddr, tt_wdata, tokens_loaded} !== {1'b1, 4'(k - 1), 32'h1200_0000 + k - 1, 5'd0}) begin
        miscompares++;
        $display("FAIL midload_wr%0d: got we=%b a=%0d d=%h tl=%0d want 1 %0d %h 0",
                 k, tt_we, tt_waddr, tt_wdata, tokens_loaded, k - 1, 32'h1200_0000 + k - 1);
      end
    end
    @(negedge clk);
    vectors++;
    if ({cpu_stall, tt_we, tokens_loaded} !== {1'b0, 1'b0, 5'd5}) begin
      miscompares++;
      $display("FAIL midload_done: got st=%b we=%b tl=%0d want 0 0 5", cpu_stall, tt_we, tokens_loaded);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_load3();
    test_empty();
    test_bad_magic();
    test_count_limits();
    test_fetch_and_reload();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
